// File: rtl/matrix_pkg.sv
// matrix_pkg
// Shared definitions for the matrix index sequencer and the downstream
// element counter stage: FSM state type, default geometry and the index
// width helper.
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mig_state_t;

  // Counter stage length; the linear address carries one extra bit.
  localparam int COUNT_LEN  = 32'sd10;
  localparam int DEF_ROWS   = 32'sd4;
  localparam int DEF_COLS   = 32'sd4;
  localparam int DEF_ADDR_W = COUNT_LEN + 32'sd1;

  // Index width for a dimension of size n: never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 32'sd1) ? 32'sd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_rc_counter.sv
// matrix_rc_counter
// Row-major 2-D wrap counter with a parallel linear address incrementer.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   clr          return to the origin (takes priority over adv)
//   adv          step to the next element
//   row, col     current coordinates
//   addr         current linear address (row*COLS+col, built by increment)
//   at_last      current coordinates are the final element
module matrix_rc_counter
  import matrix_pkg::*;
#(
  parameter  int ROWS   = DEF_ROWS,
  parameter  int COLS   = DEF_COLS,
  parameter  int ADDR_W = DEF_ADDR_W,
  localparam int RW     = idx_w(ROWS),
  localparam int CW     = idx_w(COLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              adv,
  output logic [RW-1:0]     row,
  output logic [CW-1:0]     col,
  output logic [ADDR_W-1:0] addr,
  output logic              at_last
);

  localparam logic [RW-1:0]     ROW_MAX  = RW'(ROWS - 32'sd1);
  localparam logic [CW-1:0]     COL_MAX  = CW'(COLS - 32'sd1);
  localparam logic [RW-1:0]     ROW_ONE  = RW'(32'sd1);
  localparam logic [CW-1:0]     COL_ONE  = CW'(32'sd1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(32'sd1);
  // Address of the element just before the final one.
  localparam logic [ADDR_W-1:0] ADDR_PEN = ADDR_W'(ROWS * COLS - 32'sd2);
  // A 1x1 matrix sits on its final element from the origin.
  localparam logic              SINGLE   = (ROWS == 32'sd1) && (COLS == 32'sd1);

  logic [RW-1:0]     row_r;
  logic [CW-1:0]     col_r;
  logic [ADDR_W-1:0] addr_r;
  logic              at_last_r;

  // Coordinate, address and final-element registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_r     <= {RW{1'b0}};
      col_r     <= {CW{1'b0}};
      addr_r    <= {ADDR_W{1'b0}};
      at_last_r <= SINGLE;
    end else if (clr) begin
      row_r     <= {RW{1'b0}};
      col_r     <= {CW{1'b0}};
      addr_r    <= {ADDR_W{1'b0}};
      at_last_r <= SINGLE;
    end else if (adv) begin
      if (col_r == COL_MAX) begin
        col_r <= {CW{1'b0}};
        row_r <= (row_r == ROW_MAX) ? {RW{1'b0}} : row_r + ROW_ONE;
      end else begin
        col_r <= col_r + COL_ONE;
      end
      addr_r    <= addr_r + ADDR_ONE;
      // Stepping off the penultimate address lands on the final element.
      at_last_r <= (addr_r == ADDR_PEN);
    end
  end

  assign row     = row_r;
  assign col     = col_r;
  assign addr    = addr_r;
  assign at_last = at_last_r;

endmodule

// File: rtl/matrix_index_gen.sv
// matrix_index_gen
// Walks a ROWS x COLS matrix in row-major order after a start strobe and
// presents one (row, col, addr) beat per transfer on a valid/ready port.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   start             begin a walk (accepted only when idle)
//   abort             abandon a walk in progress (no done pulse)
//   out_ready         downstream accepts the current beat
//   out_valid         row/col/addr/last are valid
//   row, col, addr    current element coordinates and linear address
//   last              current beat is the final element
//   busy              a walk or its done cycle is in progress
//   done              one-cycle pulse after the final beat is accepted
//   cnt_en            out_valid & out_ready; enable of the element counter
module matrix_index_gen
  import matrix_pkg::*;
#(
  parameter  int ROWS   = DEF_ROWS,
  parameter  int COLS   = DEF_COLS,
  parameter  int ADDR_W = DEF_ADDR_W,
  localparam int RW     = idx_w(ROWS),
  localparam int CW     = idx_w(COLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [RW-1:0]     row,
  output logic [CW-1:0]     col,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic              cnt_en
);

  localparam logic [ADDR_W-1:0] ADDR_PEN = ADDR_W'(ROWS * COLS - 32'sd2);
  localparam logic              SINGLE   = (ROWS == 32'sd1) && (COLS == 32'sd1);

  if ((ROWS < 32'sd1) || (COLS < 32'sd1) ||
      (longint'(ROWS) * longint'(COLS) > (64'sd1 <<< ADDR_W))) begin : g_bad_params
    $fatal(1, "matrix_index_gen: ROWS and COLS must be >= 1 and ROWS*COLS <= 2**ADDR_W");
  end

  mig_state_t        state_r;
  logic              out_valid_r;
  logic              last_r;
  logic              busy_r;
  logic              done_r;
  logic              xfer_s;
  logic              clr_s;
  logic              adv_s;
  logic              at_last_s;
  logic [ADDR_W-1:0] addr_s;

  matrix_rc_counter #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .ADDR_W (ADDR_W)
  ) u_rc (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr_s),
    .adv     (adv_s),
    .row     (row),
    .col     (col),
    .addr    (addr_s),
    .at_last (at_last_s)
  );

  // Counter control: parked at the origin outside RUN, cleared when the walk ends or is abandoned.
  always_comb begin
    xfer_s = out_valid_r & out_ready;
    clr_s  = 1'b1;
    adv_s  = 1'b0;
    if (state_r == RUN) begin
      clr_s = abort | (xfer_s & at_last_s);
      adv_s = xfer_s;
    end else begin
      clr_s = 1'b1;
      adv_s = 1'b0;
    end
  end

  // Walk sequencer with registered handshake and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      last_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r     <= RUN;
            out_valid_r <= 1'b1;
            busy_r      <= 1'b1;
            last_r      <= SINGLE;
          end else begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            last_r      <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            last_r      <= 1'b0;
          end else if (xfer_s && at_last_s) begin
            state_r     <= DONE;
            out_valid_r <= 1'b0;
            last_r      <= 1'b0;
            done_r      <= 1'b1;
          end else if (xfer_s) begin
            // The next beat is final when the current one is the penultimate.
            last_r <= (addr_s == ADDR_PEN);
          end else begin
            last_r <= last_r;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          last_r      <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign addr      = addr_s;
  assign last      = last_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign cnt_en    = xfer_s;

endmodule

// File: tb/tb_matrix_index_gen.sv
// Testbench for matrix_index_gen: randomized walks on a 3x5 instance scored
// against a queue of expected beats, plus directed checks on a 1x1 instance.
module tb_matrix_index_gen;
  import matrix_pkg::*;

  localparam int ROWS   = 3;
  localparam int COLS   = 5;
  localparam int ADDR_W = DEF_ADDR_W;
  localparam int RW     = idx_w(ROWS);
  localparam int CW     = idx_w(COLS);
  localparam int TOTAL  = ROWS * COLS;

  typedef struct {
    int r;
    int c;
    int a;
    bit l;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic out_ready = 1'b0;
  logic out_valid, last, busy, done, cnt_en;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [ADDR_W-1:0] addr;

  logic s_start = 1'b0;
  logic s_ready = 1'b0;
  logic s_valid, s_last, s_busy, s_done, s_cnt_en;
  logic [0:0] s_row, s_col;
  logic [ADDR_W-1:0] s_addr;

  beat_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int beats_seen = 0;
  int en_pulses = 0;
  int dones_seen = 0;
  int dones_exp = 0;
  bit done_due = 1'b0;
  bit held = 1'b0;
  logic [RW-1:0] h_row;
  logic [CW-1:0] h_col;
  logic [ADDR_W-1:0] h_addr;
  logic h_last;

  matrix_index_gen #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .out_ready(out_ready),
    .out_valid(out_valid), .row(row), .col(col), .addr(addr), .last(last),
    .busy(busy), .done(done), .cnt_en(cnt_en)
  );

  matrix_index_gen #(.ROWS(1), .COLS(1), .ADDR_W(ADDR_W)) dut1 (
    .clk(clk), .reset(reset), .start(s_start), .abort(1'b0), .out_ready(s_ready),
    .out_valid(s_valid), .row(s_row), .col(s_col), .addr(s_addr), .last(s_last),
    .busy(s_busy), .done(s_done), .cnt_en(s_cnt_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-cycle, scores transfers against the expected queue.
  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset !== 1'b1) begin
        held = 1'b0;
        done_due = 1'b0;
      end else begin
        check("cnt_en_and", cnt_en, out_valid & out_ready);
        check("done_timing", done, done_due);
        if (done === 1'b1) dones_seen++;
        done_due = 1'b0;
        if (cnt_en === 1'b1) en_pulses++;
        if (held && out_valid === 1'b1) begin
          check("stall_row", row, h_row);
          check("stall_col", col, h_col);
          check("stall_addr", addr, h_addr);
          check("stall_last", last, h_last);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", addr, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("beat_row", row, e.r);
            check("beat_col", col, e.c);
            check("beat_addr", addr, e.a);
            check("beat_last", last, e.l);
            beats_seen++;
            if (e.l && abort === 1'b0) done_due = 1'b1;
          end
        end
        held = (out_valid === 1'b1) && (out_ready !== 1'b1);
        h_row = row;
        h_col = col;
        h_addr = addr;
        h_last = last;
      end
    end
  end

  // One walk: abort_at < 0 means run to completion; rst_mid pulls reset at beat 9.
  task automatic run_walk(input int abort_at, input int ready_pct, input bit rst_mid);
    int n;
    int iters;
    bit finished;
    beat_t b;
    n = (abort_at >= 0) ? abort_at + 1 : TOTAL;
    for (int k = 0; k < n; k++) begin
      b.r = k / COLS;
      b.c = k % COLS;
      b.a = k;
      b.l = (k == TOTAL - 1);
      exp_q.push_back(b);
    end
    if (abort_at < 0 && !rst_mid) dones_exp++;
    beats_seen = 0;
    en_pulses = 0;
    start = 1'b1;
    abort = 1'b1;
    out_ready = 1'b0;
    iters = -1;
    finished = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        iters = cyc;
        finished = 1'b1;
        break;
      end
      abort = 1'b0;
      start = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(1, 100) <= ready_pct);
      if (rst_mid && beats_seen == 9) begin
        out_ready = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_row", row, 0);
        check("rst_col", col, 0);
        check("rst_addr", addr, 0);
        check("rst_last", last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt_en", cnt_en, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        finished = 1'b1;
        break;
      end
      if (abort_at >= 0 && beats_seen == abort_at) begin
        out_ready = 1'b1;
        abort = 1'b1;
      end
      #1;
      if (cyc == 0) begin
        check("first_valid", out_valid, 1);
        check("first_addr", addr, 0);
        check("first_busy", busy, 1);
      end
      if (abort === 1'b1) check("abort_cnt_en", cnt_en, 1);
    end
    if (!finished) begin
      check("walk_timeout", exp_q.size(), 0);
      exp_q.delete();
      start = 1'b0;
      abort = 1'b0;
    end else if (rst_mid) begin
      check("rst_en_pulses", en_pulses, 9);
    end else begin
      check("en_pulses", en_pulses, n);
      if (ready_pct == 100) check("throughput_cycles", iters, n);
      if (abort_at >= 0) begin
        start = 1'b0;
        abort = 1'b0;
        #1;
        check("abort_idle_valid", out_valid, 0);
        check("abort_idle_row", row, 0);
        check("abort_idle_col", col, 0);
        check("abort_idle_addr", addr, 0);
        check("abort_idle_busy", busy, 0);
      end else begin
        // DONE cycle: start and abort here must both be ignored.
        start = 1'b1;
        abort = 1'b1;
        #1;
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_valid", out_valid, 0);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        check("post_done_busy", busy, 0);
        check("post_done_done", done, 0);
        check("post_done_valid", out_valid, 0);
      end
    end
  endtask

  // Stimulus sequence.
  initial begin : stimulus
    #2;
    check("reset_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_last", last, 0);
    check("reset_addr", addr, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_walk(-1, 100, 1'b0);
    run_walk(-1, 50, 1'b0);
    run_walk(-1, 40, 1'b0);
    run_walk(5, 60, 1'b0);
    run_walk(-1, 70, 1'b0);
    run_walk(-1, 60, 1'b1);
    run_walk(-1, 100, 1'b0);
    run_walk($urandom_range(0, TOTAL - 2), 50, 1'b0);
    run_walk(TOTAL - 2, 100, 1'b0);
    run_walk(-1, 30, 1'b0);

    // 1x1 geometry: one beat with last, done next cycle, busy for two cycles.
    @(negedge clk);
    s_ready = 1'b1;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    #1;
    check("one_valid", s_valid, 1);
    check("one_last", s_last, 1);
    check("one_addr", s_addr, 0);
    check("one_cnt_en", s_cnt_en, 1);
    check("one_busy1", s_busy, 1);
    check("one_done_early", s_done, 0);
    @(negedge clk);
    #1;
    check("one_valid_after", s_valid, 0);
    check("one_done", s_done, 1);
    check("one_busy2", s_busy, 1);
    @(negedge clk);
    #1;
    check("one_busy3", s_busy, 0);
    check("one_done_clear", s_done, 0);

    repeat (3) @(negedge clk);
    check("dones_total", dones_seen, dones_exp);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/matrix_index_gen.md
# matrix_index_gen

Sequencer that walks an ROWS×COLS matrix in row-major order after a `start` strobe. It emits one (row, col, linear address) tuple per beat on a valid/ready interface. It sits directly upstream of the matrix element `counter` stage. Its `cnt_en` output is that counter's `enable` and pulses exactly once per element transferred. It also flags the final element and signals completion with a `done` pulse.

## Interface
- `ROWS`, default 4: matrix rows, ≥1
- `COLS`, default 4: matrix columns, ≥1
- `ADDR_W`, default 11: linear address width; ROWS*COLS ≤ 2^ADDR_W (elaboration-time check, fatal on violation)
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `start`  in  1  begin a matrix walk; sampled only in IDLE
- `abort`  in  1  synchronous abandon of a walk in progress
- `out_ready`  in  1  downstream accepts current beat
- `out_valid`  out  1  row/col/addr/last are valid
- `row`  out  RW=max(1,clog2(ROWS))  current row index
- `col`  out  CW=max(1,clog2(COLS))  current column index
- `addr`  out  ADDR_W  row*COLS+col
- `last`  out  1  current beat is (ROWS-1, COLS-1)
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse after the final beat is accepted
- `cnt_en`  out  1  = out_valid & out_ready (combinational); drives the counter's `enable`

## Operation
- States: IDLE, RUN, DONE.
- IDLE: out_valid=0. `start`=1 → RUN with row=col=addr=0.
- RUN: out_valid=1. A transfer is out_valid&out_ready.
  - On a transfer with col<COLS-1: col+1, addr+1.
  - On a transfer with col=COLS-1 and row<ROWS-1: col=0, row+1, addr+1.
  - On a transfer with last=1 → DONE.
- DONE: out_valid=0, done=1 for exactly one cycle, then → IDLE unconditionally.
- Backpressure: while out_valid & !out_ready, row/col/addr/last hold stable.
- `start` is ignored in RUN and DONE; no queuing.
- `abort`=1 in RUN → IDLE next cycle.
  - No done pulse.
  - Indices clear to 0.
  - A transfer coinciding with abort still counts: cnt_en=1 that cycle.
  - abort in IDLE or DONE has no effect, and DONE still pulses.
- `start` and `abort` both high in IDLE: start wins, because abort has no effect in IDLE.
- `addr` is a registered incrementer and is never computed by multiply. It wraps only if the parameter check is violated.
- `last` is registered: (row==ROWS-1)&&(col==COLS-1)&&RUN.
- ROWS=COLS=1: one beat with last=1 on the first valid cycle.
- Reset (reset=0), at any time including mid-walk:
  - state=IDLE, row=0, col=0, addr=0, out_valid=0, last=0, busy=0, done=0.
  - cnt_en=0 as a consequence.
  - No done pulse is produced for an interrupted walk.

## Timing
- start high at edge n → out_valid=1, addr=0 visible after edge n (cycle n+1).
- Throughput: 1 element/cycle with out_ready held high. A full walk occupies ROWS*COLS cycles in RUN.
- Final transfer at edge m → DONE during cycle m+1 (done=1, busy=1) → IDLE at m+2. Earliest restart: start sampled at edge m+2.
- Minimum start-to-done latency: ROWS*COLS+1 cycles.
- All outputs except cnt_en are registered. cnt_en carries one AND gate of combinational path from out_ready.
- Reset deassertion is synchronized externally. The block only requires asynchronous assertion.

## Structure
- Shared package `matrix_pkg`:
  - state enum `mig_state_t` {IDLE, RUN, DONE}
  - width helper function `idx_w(n)` = max(1, clog2(n))
  - default ROWS/COLS/ADDR_W constants, shared with the `counter` stage (ADDR_W = COUNT_LEN+1)
- One sub-module is natural: `matrix_rc_counter`.
  - Contents: the 2-D row/col wrap counter plus the linear address incrementer.
  - Inputs: `clr`, `adv`. Outputs: row, col, addr, at_last.
  - The FSM lives in the top module.

## Test plan
- ROWS=2, COLS=3, out_ready=1, pulse start → 6 beats, addr 0..5, (row,col) = (0,0)(0,1)(0,2)(1,0)(1,1)(1,2). last only on beat 6. done one cycle after beat 6. 6 cnt_en pulses; downstream counter enable count matches.
- 4×4, out_ready toggled pseudo-randomly → outputs stable during stalls, 16 transfers exactly, addr strictly sequential, done exactly once.
- 4×4, abort asserted on the transfer of addr=5 → cnt_en=1 that cycle, IDLE next cycle, no done, row=col=addr=0.
- 4×4, reset=0 asserted asynchronously mid-walk (addr=9, between edges) → all outputs 0 immediately. After release, start gives a fresh walk from addr 0.
- start pulsed during RUN and during DONE → ignored. start in the IDLE cycle after done → new walk begins at the next cycle.
- ROWS=COLS=1 → single beat with last=1 and addr=0. done next cycle. busy high for exactly 2 cycles with out_ready=1.
